// File: rtl/scytale_arbiter.sv
// Frame-level round-robin arbiter sharing one scytale_decryption core
// between two requesters; forwards bytes, routes plaintext, checks length.
module scytale_arbiter #(
  parameter int D_WIDTH = 8,
  parameter int KEY_WIDTH = 8,
  parameter logic [D_WIDTH-1:0] TERMINATOR = 'hFA,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   req0_data,
  input  logic                 req0_valid,
  input  logic [KEY_WIDTH-1:0] req0_key_N,
  input  logic [KEY_WIDTH-1:0] req0_key_M,
  output logic                 req0_ready,
  input  logic [D_WIDTH-1:0]   req1_data,
  input  logic                 req1_valid,
  input  logic [KEY_WIDTH-1:0] req1_key_N,
  input  logic [KEY_WIDTH-1:0] req1_key_M,
  output logic                 req1_ready,
  output logic [D_WIDTH-1:0]   out_data,
  output logic                 out0_valid,
  output logic                 out1_valid,
  output logic [D_WIDTH-1:0]   dec_data_i,
  output logic                 dec_valid_i,
  output logic [KEY_WIDTH-1:0] dec_key_N,
  output logic [KEY_WIDTH-1:0] dec_key_M,
  input  logic [D_WIDTH-1:0]   dec_data_o,
  input  logic                 dec_valid_o,
  input  logic                 dec_busy,
  output logic                 grant_id,
  output logic                 len_err
);

  localparam int TW = $clog2(DRAIN_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN
  } state_t;

  state_t r_state;
  state_t w_next;

  logic                 r_rr;
  logic                 r_grant;
  logic                 r_busy_seen;
  logic [15:0]          r_cnt;
  logic [TW-1:0]        r_dcnt;
  logic [KEY_WIDTH-1:0] r_key_n;
  logic [KEY_WIDTH-1:0] r_key_m;
  logic [D_WIDTH-1:0]   r_dec_data;
  logic                 r_dec_valid;
  logic                 r_len_err;

  logic               w_stream;
  logic               w_v_own;
  logic [D_WIDTH-1:0] w_d_own;
  logic               w_acc;
  logic               w_term;
  logic               w_gnt;
  logic               w_gnt_id;
  logic               w_timeout;
  logic [15:0]        w_prod;

  assign w_stream  = (r_state == S_STREAM);
  assign w_v_own   = r_grant ? req1_valid : req0_valid;
  assign w_d_own   = r_grant ? req1_data : req0_data;
  assign w_acc     = w_stream & w_v_own & ~dec_busy;
  assign w_term    = (w_d_own == TERMINATOR);
  assign w_gnt     = req0_valid | req1_valid;
  assign w_gnt_id  = (req0_valid & req1_valid) ? r_rr : req1_valid;
  assign w_timeout = (r_dcnt == TW'(DRAIN_TIMEOUT - 1));
  assign w_prod    = 16'(r_key_n) * 16'(r_key_m);

  assign req0_ready  = w_stream & ~r_grant & ~dec_busy;
  assign req1_ready  = w_stream & r_grant & ~dec_busy;
  assign out_data    = dec_data_o;
  assign out0_valid  = dec_valid_o & ~r_grant;
  assign out1_valid  = dec_valid_o & r_grant;
  assign dec_data_i  = r_dec_data;
  assign dec_valid_i = r_dec_valid;
  assign dec_key_N   = r_key_n;
  assign dec_key_M   = r_key_m;
  assign grant_id    = r_grant;
  assign len_err     = r_len_err;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_gnt) w_next = S_STREAM;
      S_STREAM: if (w_acc && w_term) w_next = S_DRAIN;
      S_DRAIN: begin
        // leave after busy rose and fell, or if it never rose in time
        if (!dec_busy && (r_busy_seen || w_timeout))
          w_next = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr        <= 1'b0;
      r_grant     <= 1'b0;
      r_busy_seen <= 1'b0;
      r_cnt       <= '0;
      r_dcnt      <= '0;
      r_key_n     <= '0;
      r_key_m     <= '0;
      r_dec_data  <= '0;
      r_dec_valid <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      r_dec_valid <= 1'b0;
      r_len_err   <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_gnt) begin
            r_grant <= w_gnt_id;
            r_key_n <= w_gnt_id ? req1_key_N : req0_key_N;
            r_key_m <= w_gnt_id ? req1_key_M : req0_key_M;
            r_cnt   <= '0;
            r_rr    <= ~w_gnt_id;
          end
        end
        S_STREAM: begin
          if (w_acc) begin
            r_dec_data  <= w_d_own;
            r_dec_valid <= 1'b1;
            if (w_term) begin
              r_len_err   <= (r_cnt != w_prod);
              r_dcnt      <= '0;
              r_busy_seen <= 1'b0;
            end else if (r_cnt != 16'hFFFF) begin
              r_cnt <= r_cnt + 16'd1;
            end
          end
        end
        S_DRAIN: begin
          if (!w_timeout) r_dcnt <= r_dcnt + TW'(1);
          if (dec_busy) r_busy_seen <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_arbiter.sv
// Scoreboard bench for scytale_arbiter: frame-level model, core model,
// decoupled driver/monitor processes.
module tb_scytale_arbiter;

  localparam logic [7:0] TERM = 8'hFA;
  localparam int DTO = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [7:0] reqd[2];
  logic       reqv[2];
  logic [7:0] keyN[2];
  logic [7:0] keyM[2];

  logic       req0_ready, req1_ready;
  logic [7:0] out_data;
  logic       out0_valid, out1_valid;
  logic [7:0] dec_data_i;
  logic       dec_valid_i;
  logic [7:0] dec_key_N, dec_key_M;
  logic       grant_id, len_err;

  logic       core_busy = 1'b0;
  logic       stall = 1'b0;
  logic       dvo = 1'b0;
  logic [7:0] ddo = 8'h00;
  wire        dec_busy = core_busy | stall;

  scytale_arbiter dut (
    .clk(clk), .rst(rst),
    .req0_data(reqd[0]), .req0_valid(reqv[0]),
    .req0_key_N(keyN[0]), .req0_key_M(keyM[0]),
    .req0_ready(req0_ready),
    .req1_data(reqd[1]), .req1_valid(reqv[1]),
    .req1_key_N(keyN[1]), .req1_key_M(keyM[1]),
    .req1_ready(req1_ready),
    .out_data(out_data),
    .out0_valid(out0_valid), .out1_valid(out1_valid),
    .dec_data_i(dec_data_i), .dec_valid_i(dec_valid_i),
    .dec_key_N(dec_key_N), .dec_key_M(dec_key_M),
    .dec_data_o(ddo), .dec_valid_o(dvo), .dec_busy(dec_busy),
    .grant_id(grant_id), .len_err(len_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic       owner;
    logic       term;
    logic       lerr;
    logic [7:0] n;
    logic [7:0] m;
    logic [7:0] data;
  } fwd_t;

  typedef struct packed {
    logic       owner;
    logic [7:0] data;
  } out_t;

  fwd_t        exp_fwd[$];
  out_t        exp_out[$];
  logic [7:0]  drv_q[2][$];
  logic [15:0] key_q[2][$];
  int unsigned acc_t[2][$];
  bit          active[2];
  bit          abort_r[2];
  bit          gap_en = 0;
  bit          nobusy = 0;
  bit          started = 0;
  bit          m_rr = 0;
  int          fwd_cnt = 0;
  string       fixed = "";

  logic [7:0] cbuf[$];
  bit         ph = 0;
  bit         fire = 0;
  bit         rs = 0;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Frame model: payload, expected forwarding, len check, plaintext route.
  task automatic push_frame(bit r, logic [7:0] n, logic [7:0] m,
                            int len, bit exp_o);
    logic [7:0] pay[$];
    logic       lerr;
    if (fixed != "") begin
      for (int i = 0; i < fixed.len(); i++) pay.push_back(fixed[i]);
      fixed = "";
    end else begin
      for (int i = 0; i < len; i++)
        pay.push_back(8'($urandom_range(0, 249)));
    end
    lerr = (pay.size() != int'(n) * int'(m));
    foreach (pay[i]) begin
      exp_fwd.push_back('{r, 1'b0, 1'b0, n, m, pay[i]});
      drv_q[r].push_back(pay[i]);
    end
    exp_fwd.push_back('{r, 1'b1, lerr, n, m, TERM});
    drv_q[r].push_back(TERM);
    key_q[r].push_back({n, m});
    if (exp_o)
      for (int i = pay.size() - 1; i >= 0; i--)
        exp_out.push_back('{r, pay[i]});
    m_rr = ~r;
  endtask

  task automatic issue_both(logic [7:0] n0, logic [7:0] m0, int l0,
                            logic [7:0] n1, logic [7:0] m1, int l1);
    bit w;
    w = m_rr;
    if (w == 0) begin
      push_frame(0, n0, m0, l0, 1);
      push_frame(1, n1, m1, l1, 1);
    end else begin
      push_frame(1, n1, m1, l1, 1);
      push_frame(0, n0, m0, l0, 1);
    end
    m_rr = w;
  endtask

  task automatic wait_done(int budget);
    int n = 0;
    int quiet = 0;
    while (n < budget && quiet < 3) begin
      @(negedge clk);
      n++;
      if (exp_fwd.size() == 0 && exp_out.size() == 0 &&
          !active[0] && !active[1] &&
          drv_q[0].size() == 0 && drv_q[1].size() == 0 &&
          !ph && !dec_busy)
        quiet++;
      else
        quiet = 0;
    end
    chk("settle", 32'(n < budget), 1);
  endtask

  task automatic chk_reset_outs();
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_dvalid", dec_valid_i, 0);
    chk("rst_ddata", dec_data_i, 0);
    chk("rst_keyN", dec_key_N, 0);
    chk("rst_keyM", dec_key_M, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_lenerr", len_err, 0);
    chk("rst_out0", out0_valid, 0);
    chk("rst_out1", out1_valid, 0);
  endtask

  task automatic driver(int r);
    bit         acc;
    logic [7:0] b;
    forever begin
      @(negedge clk);
      acc = reqv[r] && (r == 0 ? req0_ready : req1_ready) && !rst;
      if (acc) acc_t[r].push_back(cyc);
      @(posedge clk);
      #1;
      if (abort_r[r]) begin
        drv_q[r].delete();
        key_q[r].delete();
        active[r] = 0;
        reqv[r] = 0;
        abort_r[r] = 0;
      end else begin
        if (acc) begin
          b = drv_q[r].pop_front();
          if (b == TERM) begin
            active[r] = 0;
            reqv[r] = 0;
          end
        end
        if (!active[r] && drv_q[r].size() != 0) begin
          {keyN[r], keyM[r]} = key_q[r].pop_front();
          active[r] = 1;
          reqv[r] = 1;
          reqd[r] = drv_q[r][0];
        end else if (active[r] && (acc || !reqv[r])) begin
          reqv[r] = !(gap_en && $urandom_range(0, 3) == 0);
          reqd[r] = drv_q[r][0];
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      reqv[i] = 0;
      reqd[i] = 0;
      keyN[i] = 0;
      keyM[i] = 0;
    end
  end

  initial fork
    driver(0);
    driver(1);
  join_none

  // Core model: after the terminator, busy for payload+1 cycles,
  // emitting the payload back in reverse order.
  initial forever begin
    @(negedge clk);
    fire = 0;
    rs = rst;
    if (rst) begin
      cbuf.delete();
      ph = 0;
    end else if (dec_valid_i) begin
      if (dec_data_i == TERM) fire = 1;
      else cbuf.push_back(dec_data_i);
    end
    @(posedge clk);
    #1;
    if (rs) begin
      core_busy = 0;
      dvo = 0;
    end else if (fire) begin
      if (nobusy) cbuf.delete();
      else begin
        core_busy = 1;
        dvo = 0;
        ph = 1;
      end
    end else if (ph) begin
      if (cbuf.size() != 0) begin
        dvo = 1;
        ddo = cbuf.pop_back();
      end else begin
        dvo = 0;
        core_busy = 0;
        ph = 0;
      end
    end
  end

  initial forever begin
    fwd_t        e;
    out_t        o;
    int unsigned t;
    @(negedge clk);
    if (started && !rst) begin
      if (dec_valid_i) begin
        if (exp_fwd.size() == 0) begin
          chk("fwd_extra", dec_data_i, 32'hFFFF_FFFF);
        end else begin
          e = exp_fwd.pop_front();
          chk("fwd_data", dec_data_i, e.data);
          chk("fwd_owner", grant_id, e.owner);
          chk("fwd_key", {dec_key_N, dec_key_M}, {e.n, e.m});
          chk("len_err", len_err, e.term ? e.lerr : 1'b0);
          if (acc_t[e.owner].size() == 0) begin
            chk("lat_missing", 0, 1);
          end else begin
            t = acc_t[e.owner].pop_front();
            chk("latency", cyc, t + 1);
          end
          fwd_cnt++;
        end
      end else begin
        chk("len_err_idle", len_err, 0);
      end
      if (out0_valid || out1_valid) begin
        chk("out_onehot", out0_valid & out1_valid, 0);
        if (exp_out.size() == 0) begin
          chk("out_extra", out_data, 32'hFFFF_FFFF);
        end else begin
          o = exp_out.pop_front();
          chk("out_owner", out1_valid, o.owner);
          chk("out_data", out_data, o.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int k;
    int unsigned t0;
    logic [7:0] n0, m0, n1, m1;
    int l0, l1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outs();
    @(posedge clk);
    #1;
    rst = 0;
    started = 1;
    @(negedge clk);

    // T1: single requester, matching length
    fixed = "RRPNEEEAMSRAEIE?";
    push_frame(0, 4, 4, 0, 1);
    wait_done(400);

    // T2: simultaneous requests, then again
    issue_both(2, 2, 4, 1, 3, 3);
    wait_done(400);
    issue_both(1, 1, 1, 2, 1, 2);
    wait_done(400);

    // T3: 15 bytes with keys 4/4
    push_frame(0, 4, 4, 15, 1);
    wait_done(400);

    // T4: busy stall mid-stream
    push_frame(0, 4, 4, 16, 1);
    base = fwd_cnt;
    k = 0;
    while (fwd_cnt < base + 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t4_progress", 32'(k < 200), 1);
    @(posedge clk);
    #1;
    stall = 1;
    repeat (3) begin
      @(negedge clk);
      chk("t4_ready_low", req0_ready, 0);
    end
    @(posedge clk);
    #1;
    stall = 0;
    @(negedge clk);
    chk("t4_ready_back", req0_ready, 1);
    wait_done(400);

    // T5: reset in the middle of a req1 frame
    push_frame(1, 2, 2, 12, 1);
    base = fwd_cnt;
    k = 0;
    while (fwd_cnt < base + 5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t5_progress", 32'(k < 200), 1);
    @(posedge clk);
    #1;
    rst = 1;
    abort_r[1] = 1;
    exp_fwd.delete();
    exp_out.delete();
    acc_t[0].delete();
    acc_t[1].delete();
    m_rr = 0;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    chk_reset_outs();
    push_frame(0, 2, 3, 6, 1);
    wait_done(400);

    // T6: core never raises busy, drain must time out
    nobusy = 1;
    push_frame(0, 1, 2, 2, 0);
    k = 0;
    while (!req0_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk("t6_grant0", req0_ready, 1);
    push_frame(1, 2, 1, 2, 0);
    k = 0;
    while (!(dec_valid_i && dec_data_i == TERM) && k < 200) begin
      @(negedge clk);
      k++;
    end
    t0 = cyc;
    k = 0;
    while (!(req0_ready || req1_ready) && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("t6_drain_cycles", cyc - t0, DTO + 1);
    chk("t6_grant1", req1_ready, 1);
    repeat (DTO + 20) @(negedge clk);
    nobusy = 0;
    wait_done(400);

    // Random frames, with gaps in valid
    gap_en = 1;
    for (int it = 0; it < 16; it++) begin
      n0 = 8'($urandom_range(0, 4));
      m0 = 8'($urandom_range(0, 4));
      n1 = 8'($urandom_range(0, 4));
      m1 = 8'($urandom_range(0, 4));
      l0 = ($urandom_range(0, 1) == 1) ? int'(n0) * int'(m0)
                                       : int'($urandom_range(0, 12));
      l1 = ($urandom_range(0, 1) == 1) ? int'(n1) * int'(m1)
                                       : int'($urandom_range(0, 12));
      if ($urandom_range(0, 2) == 0)
        push_frame(1'($urandom_range(0, 1)), n0, m0, l0, 1);
      else
        issue_both(n0, m0, l0, n1, m1, l1);
      wait_done(2000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
